// File: rtl/pe_array_tile_sequencer.sv
// rtl/pe_array_tile_sequencer.sv - per-tile control sequencer for the PE array
//
// Walks one output tile through CLR -> BIAS -> MAC -> PACK -> OUT -> DONE.
// Ports:
//   clk, reset (async, active-low)
//   start, k_len, out_precision : tile request and config, taken only in IDLE
//   out_ready                   : downstream accepts the output beat
//   busy, done                  : status towards the layer controller
//   clear, enable_mac, enable_bias_32bits, addr_bias_32bits,
//   enable_BUFFERED_OUTPUT      : array strobes, at most one active per cycle
//   out_valid                   : output beat valid
//   mac_count                   : MAC cycles completed in the current tile
module pe_array_tile_sequencer #(
  parameter int K_WIDTH    = 16,
  parameter int PREC_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [K_WIDTH-1:0]    k_len,
  input  logic [PREC_WIDTH-1:0] out_precision,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  clear,
  output logic                  enable_mac,
  output logic                  enable_bias_32bits,
  output logic [1:0]            addr_bias_32bits,
  output logic                  enable_BUFFERED_OUTPUT,
  output logic                  out_valid,
  output logic [K_WIDTH-1:0]    mac_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_BIAS, S_MAC, S_PACK, S_OUT, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            phase_q, phase_d;
  logic [K_WIDTH-1:0]    mac_q, mac_d;
  logic [K_WIDTH-1:0]    k_q, k_d;
  logic [PREC_WIDTH-1:0] prec_q, prec_d;
  logic [1:0]            pack_len;
  state_t                after_mac;

  // Pack shifts needed to assemble one beat; code 3 behaves like 8-bit.
  always_comb begin
    pack_len = 2'd0;
    if (prec_q == PREC_WIDTH'(1)) pack_len = 2'd1;
    else if (prec_q == PREC_WIDTH'(2)) pack_len = 2'd3;
  end

  always_comb begin
    after_mac = (pack_len == 2'd0) ? S_OUT : S_PACK;
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    mac_d   = mac_q;
    k_d     = k_q;
    prec_d  = prec_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = k_len;
          prec_d  = out_precision;
          mac_d   = '0;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        phase_d = 2'd0;
        state_d = S_BIAS;
      end
      S_BIAS: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          phase_d = 2'd0;
          state_d = (k_q == '0) ? after_mac : S_MAC;
        end
      end
      S_MAC: begin
        // Saturating count; termination compares before the increment so a
        // full-scale k_len never needs a wider counter.
        if (mac_q != k_q) mac_d = mac_q + K_WIDTH'(1);
        if (mac_q == k_q - K_WIDTH'(1)) state_d = after_mac;
      end
      S_PACK: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == pack_len - 2'd1) begin
          phase_d = 2'd0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line
  // up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q                <= S_IDLE;
      phase_q                <= 2'd0;
      mac_q                  <= '0;
      k_q                    <= '0;
      prec_q                 <= '0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      clear                  <= 1'b0;
      enable_mac             <= 1'b0;
      enable_bias_32bits     <= 1'b0;
      addr_bias_32bits       <= 2'd0;
      enable_BUFFERED_OUTPUT <= 1'b0;
      out_valid              <= 1'b0;
    end else begin
      state_q                <= state_d;
      phase_q                <= phase_d;
      mac_q                  <= mac_d;
      k_q                    <= k_d;
      prec_q                 <= prec_d;
      busy                   <= (state_d != S_IDLE);
      done                   <= (state_d == S_DONE);
      clear                  <= (state_d == S_CLR);
      enable_mac             <= (state_d == S_MAC);
      enable_bias_32bits     <= (state_d == S_BIAS);
      addr_bias_32bits       <= (state_d == S_BIAS) ? phase_d : 2'd0;
      enable_BUFFERED_OUTPUT <= (state_d == S_PACK);
      out_valid              <= (state_d == S_OUT);
    end
  end

  assign mac_count = mac_q;

endmodule

// File: tb/tb_pe_array_tile_sequencer.sv
// tb/tb_pe_array_tile_sequencer.sv - scoreboard bench for pe_array_tile_sequencer
module tb_pe_array_tile_sequencer;

  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [KW-1:0] k_len;
  logic [1:0]    out_precision;
  logic          out_ready;
  logic          busy, done, clear, enable_mac, enable_bias_32bits;
  logic [1:0]    addr_bias_32bits;
  logic          enable_BUFFERED_OUTPUT, out_valid;
  logic [KW-1:0] mac_count;

  always #5 clk = ~clk;

  pe_array_tile_sequencer #(.K_WIDTH(KW), .PREC_WIDTH(2)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .k_len                  (k_len),
    .out_precision          (out_precision),
    .out_ready              (out_ready),
    .busy                   (busy),
    .done                   (done),
    .clear                  (clear),
    .enable_mac             (enable_mac),
    .enable_bias_32bits     (enable_bias_32bits),
    .addr_bias_32bits       (addr_bias_32bits),
    .enable_BUFFERED_OUTPUT (enable_BUFFERED_OUTPUT),
    .out_valid              (out_valid),
    .mac_count              (mac_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int k;
    int p;
    int s;
  } exp_t;

  exp_t sb[$];

  function automatic int pack_of(int prec);
    case (prec)
      1:       return 1;
      2:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: follows each accepted tile, tallies what the DUT shows, and
  // compares against the scoreboard entry when done is seen.
  bit   active = 1'b0;
  int   t0, clr_n, bias_n, mac_n, pack_n, val_n, strobes, idle_bad = 0;
  bit   bias_ok, macidx_ok, frozen_ok, excl_ok, busy_ok;
  exp_t e_m;

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      active = 1'b0;
    end else if (active) begin
      strobes = int'(clear) + int'(enable_mac) + int'(enable_bias_32bits)
              + int'(enable_BUFFERED_OUTPUT);
      if (strobes > 1) excl_ok = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (clear) clr_n++;
      if (enable_bias_32bits) begin
        if (int'(addr_bias_32bits) != bias_n) bias_ok = 1'b0;
        bias_n++;
      end
      if (enable_mac) begin
        if (int'(mac_count) != mac_n) macidx_ok = 1'b0;
        mac_n++;
      end
      if (enable_BUFFERED_OUTPUT) pack_n++;
      if (out_valid) begin
        val_n++;
        if (strobes != 0) frozen_ok = 1'b0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("done_without_tile", 0, 1);
        end else begin
          e_m = sb.pop_front();
          check("clear_cycles",      clr_n,            1);
          check("bias_cycles",       bias_n,           4);
          check("bias_addr_order",   int'(bias_ok),    1);
          check("mac_cycles",        mac_n,            e_m.k);
          check("mac_count_step",    int'(macidx_ok),  1);
          check("pack_cycles",       pack_n,           e_m.p);
          check("valid_cycles",      val_n,            e_m.s + 1);
          check("strobes_frozen",    int'(frozen_ok),  1);
          check("strobe_exclusive",  int'(excl_ok),    1);
          check("busy_in_tile",      int'(busy_ok),    1);
          check("start_to_done",     cyc - t0,         7 + e_m.k + e_m.p + e_m.s);
          check("final_mac_count",   int'(mac_count),  e_m.k);
        end
        active = 1'b0;
      end
    end else begin
      if (busy || done || clear || enable_mac || enable_bias_32bits ||
          enable_BUFFERED_OUTPUT || out_valid) idle_bad++;
      if (start) begin
        active    = 1'b1;
        t0        = cyc;
        clr_n     = 0;
        bias_n    = 0;
        mac_n     = 0;
        pack_n    = 0;
        val_n     = 0;
        bias_ok   = 1'b1;
        macidx_ok = 1'b1;
        frozen_ok = 1'b1;
        excl_ok   = 1'b1;
        busy_ok   = 1'b1;
      end
    end
  end

  // Driver: issues one tile, stalls out_ready for s cycles once out_valid is
  // up, optionally pulses start during MAC and/or on the done cycle.
  task automatic run_tile(int k, int prec, int s, bit mid, bit at_done);
    exp_t e;
    bit   pulsed = 1'b0;
    int   w = 0;
    e.k = k;
    e.p = pack_of(prec);
    e.s = s;
    sb.push_back(e);
    @(posedge clk); #1;
    k_len         = KW'(k);
    out_precision = 2'(prec);
    start         = 1'b1;
    out_ready     = (s == 0);
    @(posedge clk); #1;
    start         = 1'b0;
    k_len         = KW'($urandom);
    out_precision = 2'($urandom);
    while (!done && w < 2000) begin
      start = mid && enable_mac && !pulsed;
      if (start) pulsed = 1'b1;
      if (s > 0 && out_valid && !out_ready) begin
        repeat (s) @(posedge clk);
        #1 out_ready = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
      w++;
    end
    start = 1'b0;
    if (!done) begin
      check("done_timeout", 0, 1);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      sb.delete();
    end else if (at_done) begin
      start = 1'b1;
    end
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_busy"},      int'(busy),                   0);
    check({tag, "_done"},      int'(done),                   0);
    check({tag, "_clear"},     int'(clear),                  0);
    check({tag, "_en_mac"},    int'(enable_mac),             0);
    check({tag, "_en_bias"},   int'(enable_bias_32bits),     0);
    check({tag, "_addr_bias"}, int'(addr_bias_32bits),       0);
    check({tag, "_en_buf"},    int'(enable_BUFFERED_OUTPUT), 0);
    check({tag, "_out_valid"}, int'(out_valid),              0);
    check({tag, "_mac_count"}, int'(mac_count),              0);
  endtask

  initial begin
    int w;
    reset         = 1'b1;
    start         = 1'b0;
    k_len         = '0;
    out_precision = '0;
    out_ready     = 1'b1;
    #2 reset = 1'b0;
    #3 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    run_tile(5, 0, 0, 1'b0, 1'b0);
    run_tile(3, 2, 0, 1'b0, 1'b0);
    run_tile(4, 1, 6, 1'b0, 1'b0);
    run_tile(0, 0, 0, 1'b0, 1'b0);
    run_tile(8, 3, 0, 1'b1, 1'b1);
    run_tile(2, 1, 0, 1'b0, 1'b0);

    // Abort a k_len=10 tile in the middle of MAC.
    @(posedge clk); #1;
    k_len = KW'(10); out_precision = 2'd0; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    w = 0;
    while (!enable_mac && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("abort_reached_mac", int'(enable_mac), 1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("abort");
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    run_tile(2, 0, 0, 1'b0, 1'b0);
    run_tile((1 << KW) - 1, 2, 1, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      run_tile($urandom_range(0, 20), $urandom_range(0, 3), $urandom_range(0, 4),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("idle_outputs_quiet", idle_bad, 0);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
